// File: rtl/csr_exec_if.sv
// Decode-side request and writeback-side response bundle of the CSR execute stage.
// master drives the request and csr_rdata; slave is the execute stage itself.
interface csr_exec_if #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
);
    logic              halt;
    logic              valid_in;
    logic [6:0]        opcode_in;
    logic [2:0]        funct3_in;
    logic [CSR_AW-1:0] csr_addr_in;
    logic [4:0]        rs1_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [4:0]        uimm;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   csr_rdata;
    logic [CSR_AW-1:0] csr_raddr;
    logic              stall_out;
    logic              valid_out;
    logic              csr_wen;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              rd_wen;
    logic [4:0]        rd_waddr;
    logic [XLEN-1:0]   rd_wdata;
    logic              illegal_out;

    modport master (
        output halt, valid_in, opcode_in, funct3_in, csr_addr_in,
               rs1_addr, rs1_data, uimm, rd_addr, csr_rdata,
        input  csr_raddr, stall_out, valid_out, csr_wen, csr_waddr,
               csr_wdata, rd_wen, rd_waddr, rd_wdata, illegal_out
    );

    modport slave (
        input  halt, valid_in, opcode_in, funct3_in, csr_addr_in,
               rs1_addr, rs1_data, uimm, rd_addr, csr_rdata,
        output csr_raddr, stall_out, valid_out, csr_wen, csr_waddr,
               csr_wdata, rd_wen, rd_waddr, rd_wdata, illegal_out
    );
endinterface

// File: rtl/csr_exec.sv
// CSR execute stage: CSRRW/RS/RC (+ immediate forms), one-cycle registered result.
// Optional macro CSR_FWD_EN: forward the pending CSR write instead of stalling.
module csr_exec #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    csr_exec_if.slave  bus
);
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic              valid_out_reg;
    logic              illegal_reg;
    logic              csr_wen_reg;
    logic [CSR_AW-1:0] csr_waddr_reg;
    logic [XLEN-1:0]   csr_wdata_reg;
    logic              rd_wen_reg;
    logic [4:0]        rd_waddr_reg;
    logic [XLEN-1:0]   rd_wdata_reg;

    logic            csr_op;
    logic            hazard;
    logic            stall;
    logic            accept;
    logic            is_imm;
    logic            is_rw;
    logic            is_rs;
    logic            illegal_f3;
    logic            read_only;
    logic            wr_req;
    logic            illegal;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;

    assign csr_op = bus.valid_in && (bus.opcode_in == OP_SYSTEM) && (bus.funct3_in != 3'b000);

    // The CSR file only commits our registered write at the next edge, so its read data is stale.
    assign hazard = csr_op && csr_wen_reg && (csr_waddr_reg == bus.csr_addr_in);

`ifdef CSR_FWD_EN
    assign stall   = 1'b0;
    assign old_val = hazard ? csr_wdata_reg : bus.csr_rdata;
`else
    assign stall   = hazard;
    assign old_val = bus.csr_rdata;
`endif

    assign accept     = csr_op && !bus.halt && !stall;
    assign is_imm     = bus.funct3_in[2];
    assign is_rw      = (bus.funct3_in[1:0] == 2'b01);
    assign is_rs      = (bus.funct3_in[1:0] == 2'b10);
    assign illegal_f3 = (bus.funct3_in == 3'b100);
    assign read_only  = (bus.csr_addr_in[CSR_AW-1 -: 2] == 2'b11);
    assign src        = is_imm ? {{(XLEN-5){1'b0}}, bus.uimm} : bus.rs1_data;

    // Set/clear with a zero source is a pure read and must not touch the CSR.
    assign wr_req  = !illegal_f3 && (is_rw || (is_imm ? (bus.uimm != 5'd0) : (bus.rs1_addr != 5'd0)));
    assign illegal = illegal_f3 || (wr_req && read_only);

    for (genvar gi = 0; gi < XLEN; gi++) begin : g_new_bit
        assign new_val[gi] = is_rw ? src[gi] :
                             is_rs ? (old_val[gi] | src[gi]) :
                                     (old_val[gi] & ~src[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            csr_wen_reg   <= 1'b0;
            csr_waddr_reg <= '0;
            csr_wdata_reg <= '0;
            rd_wen_reg    <= 1'b0;
            rd_waddr_reg  <= '0;
            rd_wdata_reg  <= '0;
        end else if (accept) begin
            valid_out_reg <= 1'b1;
            illegal_reg   <= illegal;
            csr_wen_reg   <= wr_req && !illegal;
            csr_waddr_reg <= bus.csr_addr_in;
            csr_wdata_reg <= new_val;
            rd_wen_reg    <= !illegal && (bus.rd_addr != 5'd0);
            rd_waddr_reg  <= bus.rd_addr;
            rd_wdata_reg  <= old_val;
        end else begin
            // Strobes pulse for one cycle only; data and addresses hold.
            valid_out_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            csr_wen_reg   <= 1'b0;
            rd_wen_reg    <= 1'b0;
        end
    end

    assign bus.csr_raddr   = bus.csr_addr_in;
    assign bus.stall_out   = stall;
    assign bus.valid_out   = valid_out_reg;
    assign bus.illegal_out = illegal_reg;
    assign bus.csr_wen     = csr_wen_reg;
    assign bus.csr_waddr   = csr_waddr_reg;
    assign bus.csr_wdata   = csr_wdata_reg;
    assign bus.rd_wen      = rd_wen_reg;
    assign bus.rd_waddr    = rd_waddr_reg;
    assign bus.rd_wdata    = rd_wdata_reg;
endmodule

// File: tb/tb_csr_exec.sv
// Directed self-checking bench for csr_exec; expected values are hand-computed constants.
module tb_csr_exec;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    csr_exec_if #(.XLEN(32), .CSR_AW(12)) bus ();

    csr_exec #(.XLEN(32), .CSR_AW(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1a,
                           input logic [31:0] rs1d, input logic [4:0] imm, input logic [4:0] rd,
                           input logic [31:0] rdata);
        bus.valid_in    = 1'b1;
        bus.opcode_in   = 7'b1110011;
        bus.funct3_in   = f3;
        bus.csr_addr_in = addr;
        bus.rs1_addr    = rs1a;
        bus.rs1_data    = rs1d;
        bus.uimm        = imm;
        bus.rd_addr     = rd;
        bus.csr_rdata   = rdata;
        $display("txn f3=%0b addr=0x%03h rs1=%0d/0x%08h uimm=%0d rd=%0d rdata=0x%08h",
                 f3, addr, rs1a, rs1d, imm, rd, rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
    endtask

    task automatic chk_strobes(input string tag, input logic v, input logic cw, input logic rw, input logic il);
        chk({tag, ".valid_out"},   {31'd0, bus.valid_out},   {31'd0, v});
        chk({tag, ".csr_wen"},     {31'd0, bus.csr_wen},     {31'd0, cw});
        chk({tag, ".rd_wen"},      {31'd0, bus.rd_wen},      {31'd0, rw});
        chk({tag, ".illegal_out"}, {31'd0, bus.illegal_out}, {31'd0, il});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.halt = 1'b0;
        idle();
        bus.opcode_in = 7'd0; bus.funct3_in = 3'd0; bus.csr_addr_in = 12'd0;
        bus.rs1_addr = 5'd0; bus.rs1_data = 32'd0; bus.uimm = 5'd0;
        bus.rd_addr = 5'd0; bus.csr_rdata = 32'd0;
        #1;
        chk_strobes("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.csr_wdata", bus.csr_wdata, 32'd0);
        chk("reset.rd_wdata", bus.rd_wdata, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // CSRRW 0x340
        present(3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 5'd0, 5'd5, 32'h11);
        chk("rw.raddr", {20'd0, bus.csr_raddr}, 32'h340);
        chk("rw.stall", {31'd0, bus.stall_out}, 32'd0);
        tick();
        chk_strobes("rw", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rw.csr_waddr", {20'd0, bus.csr_waddr}, 32'h340);
        chk("rw.csr_wdata", bus.csr_wdata, 32'hDEADBEEF);
        chk("rw.rd_waddr", {27'd0, bus.rd_waddr}, 32'd5);
        chk("rw.rd_wdata", bus.rd_wdata, 32'h11);
        idle();
        tick();
        chk_strobes("rw_drop", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rw_hold.csr_wdata", bus.csr_wdata, 32'hDEADBEEF);

        // CSRRSI uimm=0 on read-only 0xC00: legal read
        present(3'b110, 12'hC00, 5'd0, 32'd0, 5'd0, 5'd7, 32'h1234);
        tick();
        chk_strobes("rsi_ro", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rsi_ro.rd_wdata", bus.rd_wdata, 32'h1234);

        // CSRRW on read-only 0xC00: illegal
        present(3'b001, 12'hC00, 5'd2, 32'h5, 5'd0, 5'd7, 32'h1234);
        tick();
        chk_strobes("rw_ro", 1'b1, 1'b0, 1'b0, 1'b1);

        // funct3 100: illegal
        present(3'b100, 12'h340, 5'd2, 32'h5, 5'd0, 5'd7, 32'h0);
        tick();
        chk_strobes("f3_100", 1'b1, 1'b0, 1'b0, 1'b1);

        // CSRRC 0xFF & ~0x0F
        present(3'b011, 12'h341, 5'd3, 32'h0F, 5'd0, 5'd4, 32'hFF);
        tick();
        chk_strobes("rc", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rc.csr_wdata", bus.csr_wdata, 32'hF0);
        idle();
        tick();
        present(3'b011, 12'h341, 5'd3, 32'h0F, 5'd0, 5'd0, 32'hFF);
        tick();
        chk_strobes("rc_rd0", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rc_rd0.csr_wdata", bus.csr_wdata, 32'hF0);
        idle();
        tick();

        // funct3 000 and non-SYSTEM opcode are ignored
        present(3'b000, 12'h342, 5'd1, 32'h1, 5'd0, 5'd5, 32'h0);
        tick();
        chk_strobes("f3_000", 1'b0, 1'b0, 1'b0, 1'b0);
        present(3'b001, 12'h342, 5'd1, 32'h1, 5'd0, 5'd5, 32'h0);
        bus.opcode_in = 7'b0110011;
        tick();
        chk_strobes("not_sys", 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back same CSR: RW 0x300 <- 0xA5, then RS 0x300 with 0x100
        present(3'b001, 12'h300, 5'd1, 32'hA5, 5'd0, 5'd6, 32'h0);
        tick();
        chk("b2b1.csr_wdata", bus.csr_wdata, 32'hA5);
        present(3'b010, 12'h300, 5'd2, 32'h100, 5'd0, 5'd6, 32'h0);
`ifdef CSR_FWD_EN
        chk("b2b.stall", {31'd0, bus.stall_out}, 32'd0);
        tick();
`else
        chk("b2b.stall", {31'd0, bus.stall_out}, 32'd1);
        tick();
        chk_strobes("b2b_bubble", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.csr_rdata = 32'hA5;
        chk("b2b.stall_clear", {31'd0, bus.stall_out}, 32'd0);
        tick();
`endif
        chk_strobes("b2b2", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("b2b2.csr_wdata", bus.csr_wdata, 32'h1A5);
        chk("b2b2.rd_wdata", bus.rd_wdata, 32'hA5);
        idle();
        tick();

        // Halt: pending write pulses once, presented op waits for halt to fall
        present(3'b001, 12'h305, 5'd1, 32'h77, 5'd0, 5'd8, 32'h0);
        tick();
        chk_strobes("pre_halt", 1'b1, 1'b1, 1'b1, 1'b0);
        bus.halt = 1'b1;
        present(3'b001, 12'h306, 5'd1, 32'h88, 5'd0, 5'd9, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_strobes("halt", 1'b0, 1'b0, 1'b0, 1'b0);
            chk("halt.csr_wdata", bus.csr_wdata, 32'h77);
        end
        bus.halt = 1'b0;
        tick();
        chk_strobes("post_halt", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("post_halt.csr_waddr", {20'd0, bus.csr_waddr}, 32'h306);
        chk("post_halt.csr_wdata", bus.csr_wdata, 32'h88);
        idle();
        tick();

        // Reset asserted mid-op clears the pending write immediately
        present(3'b001, 12'h307, 5'd1, 32'h99, 5'd0, 5'd10, 32'h3);
        tick();
        chk_strobes("pre_rst", 1'b1, 1'b1, 1'b1, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk_strobes("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst.csr_wdata", bus.csr_wdata, 32'd0);
        chk("mid_rst.rd_wdata", bus.rd_wdata, 32'd0);
        chk("mid_rst.csr_waddr", {20'd0, bus.csr_waddr}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_strobes("after_rst", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
